seg_scan_driver: RTL

Parametrised multiplexed seven-segment scan driver, successor to the fixed 8-digit Display block. Drives NUM_DIGITS common-anode digits from a packed BCD bus, with tear-free frame-synchronous loading, per-digit blinking (alarm-set feedback), decimal points and global blanking. Sits between the clock/alarm digit mux and the board anode/cathode pins.

---
 rtl/seg_scan_driver.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode seven-segment scan driver.
// Scans NUM_DIGITS digits from a shadow register that is only updated at
// frame wrap, so a load never tears a frame. Supports per-digit blink,
// decimal points and global blanking. All anode/cathode outputs are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   A,
  output logic [7:0]              C,
  output logic                    frame_done,
  output logic                    load_pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    blink_q, blink_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] stage_dig_q, shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, shadow_dp_q, shadow_dp_d;
  logic                    step, wrap, commit;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    dark, lz_blank;
  logic [NUM_DIGITS-1:0]   a_d;
  logic [7:0]              c_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0]           msd;
`endif

  // Active-low segment pattern g..a for one BCD code; dp handled separately.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      4'd10:   seg_decode = 7'h3F;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Next-state for scan counters, blink phase and the stage/shadow handoff.
  // A/C are driven from the *next* index and shadow, so the pins change on
  // the same edge the index does and a fresh frame starts with fresh data.
  always_comb begin
    step    = (presc_q == PRESC_LAST);
    wrap    = step && (idx_q == IDX_LAST);
    presc_d = step ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (wrap)      idx_d = '0;
    else if (step) idx_d = idx_q + IW'(1);

    frame_d = frame_q;
    blink_d = blink_q;
    if (wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    // A load on the wrap cycle stages new data; the old staged data (if any)
    // still commits on this wrap and the new data waits for the next one.
    commit       = wrap && pending_q;
    shadow_dig_d = commit ? stage_dig_q : shadow_dig_q;
    shadow_dp_d  = commit ? stage_dp_q  : shadow_dp_q;
    pending_d    = load | (pending_q & ~wrap);
  end

  // Pixel for the digit that becomes active on the coming edge.
  always_comb begin
    cur_code = shadow_dig_d[{idx_d, 2'b00} +: 4];
    cur_dp   = shadow_dp_d[idx_d];
    dark     = blink_d && blink_mask[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (shadow_dig_d[4*i +: 4] != 4'd0) msd = IW'(i);
    end
    lz_blank = (idx_d > msd) && (cur_code == 4'd0) && !cur_dp;
`else
    lz_blank = 1'b0;
`endif
    a_d = '1;
    c_d = '1;
    if (enable && !dark) begin
      a_d = ~(NUM_DIGITS'(1) << idx_d);
      if (!lz_blank) c_d = {~cur_dp, seg_decode(cur_code)};
    end
  end

  // Scan counters, blink phase, staging and shadow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      blink_q      <= 1'b0;
      pending_q    <= 1'b0;
      stage_dig_q  <= '0;
      stage_dp_q   <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      pending_q    <= pending_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      if (load) begin
        stage_dig_q <= digits_in;
        stage_dp_q  <= dp_in;
      end
    end
  end

  // Registered pin drivers and frame wrap pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A          <= '1;
      C          <= '1;
      frame_done <= 1'b0;
    end else begin
      A          <= a_d;
      C          <= c_d;
      frame_done <= wrap;
    end
  end

  assign load_pending = pending_q;

endmodule
